// File: rtl/sine_gen_pkg.sv
// Shared types and defaults for the sine generator and its sweep sequencer.
package sine_gen_pkg;
   localparam int PHASE_W_DEF = 32;

   typedef enum logic {
      IDLE  = 1'b0,
      SWEEP = 1'b1
   } sweep_state_t;
endpackage

// File: rtl/sweep_dwell_timer.sv
// Loadable down-counter; o_tc is high while the count sits at zero.
module sweep_dwell_timer #(
   parameter int W = 32
) (
   input  logic         i_clk,
   input  logic         i_rst_n,
   input  logic         i_load,
   input  logic [W-1:0] i_value,
   input  logic         i_enable,
   output logic         o_tc
);
   logic [W-1:0] count_q;
   logic [W-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (i_load) begin
         count_d = i_value;
      end else if (i_enable && (count_q != '0)) begin
         count_d = count_q - W'(1);
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign o_tc = (count_q == '0);
endmodule

// File: rtl/sine_sweep_ctrl.sv
// Steps the generator phase increment from start to stop in fixed increments,
// holding each for a dwell count; single-shot or continuous.
module sine_sweep_ctrl
   import sine_gen_pkg::*;
#(
   parameter int PHASE_W = PHASE_W_DEF,
   parameter int DWELL_W = 32,
   parameter int IDX_W   = 16
) (
   input  logic               i_clk,
   input  logic               i_rst_n,
   input  logic               i_start,
   input  logic               i_abort,
   input  logic [PHASE_W-1:0] i_start_inc,
   input  logic [PHASE_W-1:0] i_stop_inc,
   input  logic [PHASE_W-1:0] i_step_inc,
   input  logic [DWELL_W-1:0] i_dwell,
   input  logic               i_continuous,
   output logic [PHASE_W-1:0] o_phase_adder,
   output logic               o_step_valid,
   output logic [IDX_W-1:0]   o_step_idx,
   output logic               o_busy,
   output logic               o_done
);
   sweep_state_t state_q, state_d;

   logic [PHASE_W-1:0] start_q, start_d;
   logic [PHASE_W-1:0] stop_q, stop_d;
   logic [PHASE_W-1:0] step_q, step_d;
   logic [DWELL_W-1:0] dwm1_q, dwm1_d;
   logic               cont_q, cont_d;
   logic [PHASE_W-1:0] phase_q, phase_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic               valid_q, valid_d;
   logic               done_q, done_d;

   logic               tmr_load;
   logic               tmr_en;
   logic               tmr_tc;
   logic [DWELL_W-1:0] tmr_val;
   logic [DWELL_W-1:0] in_dwm1;
   logic [PHASE_W:0]   next_sum;
   logic               last_step;

   // A zero dwell is treated as one cycle per step.
   assign in_dwm1 = (i_dwell == '0) ? '0 : i_dwell - DWELL_W'(1);

   assign next_sum  = {1'b0, phase_q} + {1'b0, step_q};
   assign last_step = (step_q == '0) || next_sum[PHASE_W]
                   || (next_sum > {1'b0, stop_q});

   always_comb begin
      state_d  = state_q;
      start_d  = start_q;
      stop_d   = stop_q;
      step_d   = step_q;
      dwm1_d   = dwm1_q;
      cont_d   = cont_q;
      phase_d  = phase_q;
      idx_d    = idx_q;
      valid_d  = 1'b0;
      done_d   = 1'b0;
      tmr_load = 1'b0;
      tmr_en   = 1'b0;
      tmr_val  = dwm1_q;
      unique case (state_q)
         IDLE: begin
            if (i_start && !i_abort) begin
               state_d  = SWEEP;
               start_d  = i_start_inc;
               stop_d   = i_stop_inc;
               step_d   = i_step_inc;
               dwm1_d   = in_dwm1;
               cont_d   = i_continuous;
               phase_d  = i_start_inc;
               idx_d    = '0;
               valid_d  = 1'b1;
               tmr_load = 1'b1;
               tmr_val  = in_dwm1;
            end
         end
         SWEEP: begin
            if (i_abort) begin
               state_d = IDLE;
               phase_d = '0;
               idx_d   = '0;
            end else if (tmr_tc) begin
               if (!last_step) begin
                  phase_d  = next_sum[PHASE_W-1:0];
                  idx_d    = idx_q + IDX_W'(1);
                  valid_d  = 1'b1;
                  tmr_load = 1'b1;
               end else if (cont_q) begin
                  phase_d  = start_q;
                  idx_d    = '0;
                  valid_d  = 1'b1;
                  tmr_load = 1'b1;
               end else begin
                  state_d = IDLE;
                  phase_d = '0;
                  idx_d   = '0;
                  done_d  = 1'b1;
               end
            end else begin
               tmr_en = 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
            phase_d = '0;
            idx_d   = '0;
         end
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= IDLE;
         start_q <= '0;
         stop_q  <= '0;
         step_q  <= '0;
         dwm1_q  <= '0;
         cont_q  <= 1'b0;
         phase_q <= '0;
         idx_q   <= '0;
         valid_q <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         start_q <= start_d;
         stop_q  <= stop_d;
         step_q  <= step_d;
         dwm1_q  <= dwm1_d;
         cont_q  <= cont_d;
         phase_q <= phase_d;
         idx_q   <= idx_d;
         valid_q <= valid_d;
         done_q  <= done_d;
      end
   end

   sweep_dwell_timer #(
      .W (DWELL_W)
   ) u_timer (
      .i_clk    (i_clk),
      .i_rst_n  (i_rst_n),
      .i_load   (tmr_load),
      .i_value  (tmr_val),
      .i_enable (tmr_en),
      .o_tc     (tmr_tc)
   );

   assign o_phase_adder = phase_q;
   assign o_step_valid  = valid_q;
   assign o_step_idx    = idx_q;
   assign o_busy        = (state_q == SWEEP);
   assign o_done        = done_q;
endmodule

// File: tb/tb_sine_sweep_ctrl.sv
// Directed and randomized sweeps checked against a step-list reference model.
module tb_sine_sweep_ctrl;
   logic        clk;
   logic        rst_n;
   logic        start;
   logic        abort;
   logic [31:0] start_inc;
   logic [31:0] stop_inc;
   logic [31:0] step_inc;
   logic [31:0] dwell;
   logic        cont;
   logic [31:0] phase;
   logic        valid;
   logic [15:0] idx;
   logic        busy;
   logic        done;

   int vectors = 0;
   int errors  = 0;

   sine_sweep_ctrl dut (
      .i_clk         (clk),
      .i_rst_n       (rst_n),
      .i_start       (start),
      .i_abort       (abort),
      .i_start_inc   (start_inc),
      .i_stop_inc    (stop_inc),
      .i_step_inc    (step_inc),
      .i_dwell       (dwell),
      .i_continuous  (cont),
      .o_phase_adder (phase),
      .o_step_valid  (valid),
      .o_step_idx    (idx),
      .o_busy        (busy),
      .o_done        (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Number of steps: every start + n*step that stays within stop.
   function automatic longint calc_n(input longint s, input longint e,
                                     input longint st);
      if (st > 0 && s <= e) return (e - s) / st + 1;
      return 1;
   endfunction

   function automatic longint calc_d(input longint d);
      return (d == 0) ? 1 : d;
   endfunction

   task automatic chk_idle(input string tag, input logic exp_done);
      chk({tag, ".phase"}, 64'(phase), 64'd0);
      chk({tag, ".busy"}, 64'(busy), 64'd0);
      chk({tag, ".valid"}, 64'(valid), 64'd0);
      chk({tag, ".idx"}, 64'(idx), 64'd0);
      chk({tag, ".done"}, 64'(done), 64'(exp_done));
   endtask

   task automatic run_single(input longint s, input longint e,
                             input longint st, input longint dw);
      longint n, d, k, total;
      n = calc_n(s, e, st);
      d = calc_d(dw);
      total = n * d;
      @(negedge clk);
      start_inc = 32'(s);
      stop_inc  = 32'(e);
      step_inc  = 32'(st);
      dwell     = 32'(dw);
      cont      = 1'b0;
      start     = 1'b1;
      for (longint c = 0; c <= total; c++) begin
         @(negedge clk);
         start = 1'b0;
         if (c < total) begin
            k = c / d;
            chk("sgl.phase", 64'(phase), 64'(s + k * st));
            chk("sgl.idx", 64'(idx), 64'(k % 65536));
            chk("sgl.valid", 64'(valid), 64'((c % d) == 0));
            chk("sgl.busy", 64'(busy), 64'd1);
            chk("sgl.done", 64'(done), 64'd0);
         end else begin
            chk_idle("sgl.end", 1'b1);
         end
         if (c == 1 && total > 2) begin
            start     = 1'b1;
            start_inc = $urandom;
            stop_inc  = $urandom;
            step_inc  = $urandom;
            dwell     = $urandom_range(0, 9);
            cont      = 1'b1;
         end
      end
      @(negedge clk);
      chk_idle("sgl.after", 1'b0);
   endtask

   task automatic run_cont(input longint s, input longint e,
                           input longint st, input longint dw,
                           input int ncyc);
      longint n, d, k;
      n = calc_n(s, e, st);
      d = calc_d(dw);
      @(negedge clk);
      start_inc = 32'(s);
      stop_inc  = 32'(e);
      step_inc  = 32'(st);
      dwell     = 32'(dw);
      cont      = 1'b1;
      start     = 1'b1;
      for (int c = 0; c < ncyc; c++) begin
         @(negedge clk);
         start = 1'b0;
         k = (longint'(c) / d) % n;
         chk("cnt.phase", 64'(phase), 64'(s + k * st));
         chk("cnt.idx", 64'(idx), 64'(k));
         chk("cnt.valid", 64'(valid), 64'((longint'(c) % d) == 0));
         chk("cnt.busy", 64'(busy), 64'd1);
         chk("cnt.done", 64'(done), 64'd0);
      end
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      chk_idle("cnt.abort", 1'b0);
      @(negedge clk);
      chk_idle("cnt.abort2", 1'b0);
   endtask

   initial begin
      longint s, st, e;
      rst_n = 1'b0;
      start = 1'b0;
      abort = 1'b0;
      start_inc = '0;
      stop_inc  = '0;
      step_inc  = '0;
      dwell     = '0;
      cont      = 1'b0;
      #12;
      chk_idle("reset", 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk_idle("post_reset", 1'b0);

      run_single(0, 3000, 1000, 4);
      run_single(64'hFFFF_FF00, 64'hFFFF_FFFF, 64'h200, 1);
      run_single(0, 20, 10, 0);
      run_single(77, 1000, 0, 3);
      run_single(5000, 1000, 7, 2);
      run_single(64'hFFFF_FFF0, 64'hFFFF_FFFF, 4, 1);

      run_cont(100, 300, 100, 2, 15);
      run_cont(10, 10, 5, 1, 5);

      for (int i = 0; i < 10; i++) begin
         s  = longint'($urandom);
         st = longint'($urandom_range(1, 1000));
         e  = s + longint'($urandom_range(0, 5)) * st
                + longint'($urandom_range(0, 999)) % st;
         if (e > 64'hFFFF_FFFF) e = 64'hFFFF_FFFF;
         if (i % 5 == 3) st = 0;
         if (i % 5 == 4) e = s / 2;
         if (i % 2 == 0)
            run_single(s, e, st, longint'($urandom_range(0, 4)));
         else
            run_cont(s, e, st, longint'($urandom_range(0, 3)),
                     int'($urandom_range(3, 30)));
      end

      @(negedge clk);
      start_inc = 32'd1234;
      stop_inc  = 32'd9999;
      step_inc  = 32'd1;
      dwell     = 32'd2;
      cont      = 1'b0;
      start     = 1'b1;
      abort     = 1'b1;
      @(negedge clk);
      start = 1'b0;
      abort = 1'b0;
      chk_idle("start_abort", 1'b0);
      @(negedge clk);
      chk_idle("start_abort2", 1'b0);

      @(negedge clk);
      start_inc = 32'd0;
      stop_inc  = 32'd1000;
      step_inc  = 32'd10;
      dwell     = 32'd3;
      start     = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      chk("rst.busy_before", 64'(busy), 64'd1);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1 chk_idle("rst_mid", 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk_idle("rst_after", 1'b0);

      run_single(0, 3000, 1000, 4);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end
endmodule

// File: doc/sine_sweep_ctrl.md
# sine_sweep_ctrl

Frequency-sweep sequencer for `sine_wave_gen_quarter`. It drives the generator's `i_phase_adder` through a programmed staircase of phase increments. Each increment is held for a fixed dwell count, covering start to stop in constant steps, once or continuously. It replaces bench-driven sweeps with a hardware scheduler and gives downstream capture logic per-step framing strobes.

## Interface
Parameters:
- `PHASE_W`, default 32: phase increment width; must equal the generator's `i_phase_adder` width.
- `DWELL_W`, default 32: dwell counter width.
- `IDX_W`, default 16: step index width.

Ports:
- `i_clk`, in, 1: single clock.
- `i_rst_n`, in, 1: asynchronous, active-low reset.
- `i_start`, in, 1: start request; single-cycle pulse.
- `i_abort`, in, 1: abort request; single-cycle pulse.
- `i_start_inc`, in, `PHASE_W`: first phase increment.
- `i_stop_inc`, in, `PHASE_W`: last allowed increment, inclusive.
- `i_step_inc`, in, `PHASE_W`: amount added per step, unsigned.
- `i_dwell`, in, `DWELL_W`: cycles per step; 0 is treated as 1.
- `i_continuous`, in, 1: 1 means wrap to start after the last step.
- `o_phase_adder`, out, `PHASE_W`: connects to the generator's `i_phase_adder`.
- `o_step_valid`, out, 1: one-cycle pulse in the first cycle of every step.
- `o_step_idx`, out, `IDX_W`: index of the current step; wraps modulo 2^`IDX_W`.
- `o_busy`, out, 1: high while sweeping.
- `o_done`, out, 1: one-cycle pulse when a single sweep completes.

## Operation
- States:
  - `IDLE`: `o_phase_adder` = 0, which freezes the generator.
  - `SWEEP`: a sweep is in progress.
- `IDLE` → `SWEEP` on `i_start`=1 with `i_abort`=0.
  - Latch all configuration inputs; they are ignored until the next start.
  - `o_phase_adder` = start_inc, `o_step_idx` = 0, `o_step_valid` = 1, dwell counter = D-1, where D = max(`i_dwell`, 1).
- In `SWEEP`, the dwell counter decrements each cycle. When it reaches 0:
  - Form next = cur + step at `PHASE_W`+1 bits.
  - If step = 0, or next > stop, or next carries out (bit `PHASE_W` set), the sweep ends. Otherwise load next, increment the index, pulse `o_step_valid`, and reload the counter to D-1.
- Sweep end:
  - Continuous mode: reload start_inc, index 0, pulse `o_step_valid`, remain in `SWEEP`; `o_done` does not pulse.
  - Single mode: go to `IDLE`, pulse `o_done`, drive `o_phase_adder`=0 and `o_busy`=0.
- start_inc > stop_inc: exactly one step at start_inc, then the sweep ends.
- `i_abort` in `SWEEP`: go to `IDLE` on the next edge, `o_phase_adder`=0, no `o_done`.
  - `i_abort` has priority over a step update in the same cycle.
- `i_start` in `SWEEP` is ignored; no restart.
- `i_start` together with `i_abort` in `IDLE`: abort wins and the sweep does not start.
- Reset, including mid-sweep: state `IDLE`; all outputs 0 (`o_phase_adder`, `o_step_idx`, `o_step_valid`, `o_busy`, `o_done`).

## Timing
- Start sampled at edge k → at k+1: `o_phase_adder`=start_inc, `o_busy`=1, `o_step_valid`=1.
- Each step holds exactly D cycles, so step n begins at k+1+n·D.
- Single sweep with N steps: `o_busy` high N·D cycles. `o_done` is high in the cycle after the last step's final cycle (k+1+N·D), coincident with `o_busy`=0 and `o_phase_adder`=0.
  - N = floor((stop-start)/step)+1 when start ≤ stop and step > 0; otherwise N = 1.
- Abort sampled at edge a → `o_busy`=0 and `o_phase_adder`=0 at a+1.
- The earliest restart after `o_done` is the start sampled in that same `o_done` cycle.
- All outputs are registered; there are no combinational input-to-output paths.

## Structure
- Shared package `sine_gen_pkg`: `PHASE_W` default constant and the `sweep_state_t` enum (`IDLE`, `SWEEP`).
- Sub-module `sweep_dwell_timer`: loadable down-counter with a terminal-count flag; inputs load, value, enable.
- Top-level: the FSM, the `PHASE_W`+1-bit next-increment adder and compare, and the configuration latches.

## Test plan
- **Basic single sweep.** start=0, stop=3000, step=1000, dwell=4 → `o_phase_adder` 0/1000/2000/3000, each for 4 cycles. `o_step_idx` 0..3, four `o_step_valid` pulses, `o_busy` 16 cycles, `o_done` at k+17, then output 0.
- **Continuous mode, then abort.** Continuous, start=100, stop=300, step=100, dwell=2 → 100,200,300,100,200… with index resetting to 0 and no `o_done`. Abort mid-step → output 0 and `o_busy`=0 one cycle later, no `o_done`.
- **Carry-out termination.** start=0xFFFF_FF00, step=0x200, stop=0xFFFF_FFFF, dwell=1 → exactly one step of 0xFFFF_FF00 (next sum carries out), then `o_done`.
- **Degenerate configurations.**
  - dwell=0 behaves as dwell=1.
  - step=0 gives one dwell at start, then `o_done`.
  - start=5000 with stop=1000 gives one step at 5000, then `o_done`.
- **Control conflicts and reset.**
  - `i_start` during a sweep is ignored, and config changes mid-sweep have no effect.
  - Start with abort in `IDLE` → no sweep.
  - Asserting `i_rst_n`=0 mid-sweep, between clock edges → all outputs 0 immediately.
